// File: rtl/button_debouncer.sv
// Debounces one raw pushbutton into a clean level plus one-cycle press/release pulses.
// Optional auto-repeat of rise_pulse while held: define BUTTON_DEBOUNCER_REPEAT_EN.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("button_debouncer: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
    $error("button_debouncer: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Input capture flop plus SYNC_STAGES metastability flops; this alignment puts the
  // accepted level exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after btn_in is first sampled.
  logic [SYNC_STAGES:0] sync_r;
  logic                 btn_s;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;

  assign btn_s = sync_r[SYNC_STAGES];

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_r;
  logic             rep_armed_r;
  logic [REP_W-1:0] rep_target_s;
  logic             rep_fire_s;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign rep_target_s = rep_armed_r ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
  assign rep_fire_s   = ((rep_cnt_r + REP_W'(1)) == rep_target_s);
`endif

  // Synchronizer shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-1:0], btn_in};
    end
  end

  // Debounce FSM with stability counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_LOW;
      cnt_r       <= '0;
      btn_level   <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      rep_cnt_r   <= '0;
      rep_armed_r <= 1'b0;
`endif
    end else begin
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      rep_cnt_r   <= '0;
      rep_armed_r <= 1'b0;
`endif
      case (state_r)
        S_LOW: begin
          if (btn_s) begin
            state_r <= S_WAIT_HIGH;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!btn_s) begin
            state_r    <= S_LOW;
            cnt_r      <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= S_HIGH;
            cnt_r      <= '0;
            btn_level  <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt_r      <= cnt_r + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!btn_s) begin
            state_r <= S_WAIT_LOW;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= '0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
            if (rep_fire_s) begin
              rise_pulse  <= 1'b1;
              rep_cnt_r   <= '0;
              rep_armed_r <= 1'b1;
            end else begin
              rep_cnt_r   <= rep_cnt_r + REP_W'(1);
              rep_armed_r <= rep_armed_r;
            end
`endif
          end
        end
        S_WAIT_LOW: begin
          if (btn_s) begin
            state_r    <= S_HIGH;
            cnt_r      <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= S_LOW;
            cnt_r      <= '0;
            btn_level  <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt_r      <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= S_LOW;
          cnt_r     <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed, table-driven bench for button_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Repeat checks follow BUTTON_DEBOUNCER_REPEAT_EN when it is defined for the build.
module tb_button_debouncer;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 3;
  localparam int REPEAT_DELAY    = 10;
  localparam int REPEAT_PERIOD   = 5;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level;
  logic rise_pulse;
  logic fall_pulse;

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic rst;
    logic btn;
    logic level;
    logic rise;
    logic fall;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  task automatic add(input logic r, input logic b, input logic l, input logic ri,
                     input logic f, input int n);
    vec_t v;
    v.rst = r; v.btn = b; v.level = l; v.rise = ri; v.fall = f;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // One clock: drive inputs, take the edge, compare outputs 1 time unit later.
  task automatic step(input logic r, input logic b, input logic l, input logic ri,
                      input logic f, input string tag, input int idx);
    rst = r;
    btn_in = b;
    @(posedge clk);
    #1;
    applied++;
    if ({btn_level, rise_pulse, fall_pulse} !== {l, ri, f}) begin
      miscompares++;
      $display("FAIL %s[%0d]: level/rise/fall got %b%b%b expected %b%b%b",
               tag, idx, btn_level, rise_pulse, fall_pulse, l, ri, f);
    end
  endtask

  initial begin
    // reset held 3 cycles with button pressed, then re-qualified as a fresh press
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    // clean release from S_HIGH
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    // bounce 1,1,1,0 then stable 1: accepted 6 edges after the final 0->1
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].btn, vecs[i].level, vecs[i].rise, vecs[i].fall, "table", i);

    // release glitches of 2 and 3 cycles must not change the level
    for (int i = 0; i < 20; i++)
      step(1'b0, (i >= 2), 1'b1, 1'b0, 1'b0, "glitch2", i);
    for (int i = 0; i < 20; i++)
      step(1'b0, (i >= 3), 1'b1, 1'b0, 1'b0, "glitch3", i);

    // one-cycle reset while high: level drops, no fall pulse
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst", 0);
    for (int i = 1; i < 11; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst", i);

    // long hold: single rise without repeat, or the repeat schedule with it
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_q", i);
    for (int k = 0; k <= 30; k++) begin
      logic exp_rise;
      exp_rise = (k == 0) ||
                 (REPEAT_ON && k >= REPEAT_DELAY && ((k - REPEAT_DELAY) % REPEAT_PERIOD) == 0);
      step(1'b0, 1'b1, 1'b1, exp_rise, 1'b0, "hold", k);
    end
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, (k < 6), 1'b0, (k == 6), "release", k);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
